// File: rtl/ecc_mem_responder_if.sv
// ----------------------------------------------------------------------------
// ecc_mem_responder_if
// Purpose : request/response bus between a requester and ecc_mem_responder.
//           The requester uses the master modport and the responder uses the
//           slave modport.
// Signals : req_valid/req_ready/req_we/req_addr/sel     request handshake
//           wdata_up/wdata_down                         write data, [0:15]
//           inj_en/inj_mask_up/inj_mask_down            fault injection
//           rsp_valid/rsp_ready/rdata_up/rdata_down     read response
//           inj_count                                   injected-write count
// ----------------------------------------------------------------------------
interface ecc_mem_responder_if #(
    parameter int DEPTH = 16
) ();
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [AW-1:0]   req_addr;
    logic [1:0]      sel;
    logic [0:15]     wdata_up;
    logic [0:15]     wdata_down;
    logic            inj_en;
    logic [0:15]     inj_mask_up;
    logic [0:15]     inj_mask_down;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [0:15]     rdata_up;
    logic [0:15]     rdata_down;
    logic [7:0]      inj_count;

    modport master (
        output req_valid, req_we, req_addr, sel, wdata_up, wdata_down,
               inj_en, inj_mask_up, inj_mask_down, rsp_ready,
        input  req_ready, rsp_valid, rdata_up, rdata_down, inj_count
    );

    modport slave (
        input  req_valid, req_we, req_addr, sel, wdata_up, wdata_down,
               inj_en, inj_mask_up, inj_mask_down, rsp_ready,
        output req_ready, rsp_valid, rdata_up, rdata_down, inj_count
    );
endinterface

// File: rtl/ecc_mem_responder.sv
// ----------------------------------------------------------------------------
// ecc_mem_responder
// Purpose : two 16-bit memory banks ("up" and "down") that together hold a
//           32-bit ECC word. Writes complete in the accept cycle, with an
//           optional XOR fault-injection mask. Reads are returned through a
//           valid/ready response two cycles after acceptance.
// Ports   : clk    rising-edge clock
//           rst_n  synchronous active-low reset
//           bus    ecc_mem_responder_if slave modport (request, response,
//                  fault injection and inj_count)
// ----------------------------------------------------------------------------
module ecc_mem_responder #(
    parameter int DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ecc_mem_responder_if.slave   bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Address limit held one bit wider so DEPTH itself is representable.
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_stateNext;
    logic          w_reqReady;
    logic          w_rspValid;

    logic [0:15]   r_memUp   [DEPTH];
    logic [0:15]   r_memDown [DEPTH];

    logic [AW-1:0] r_addr;
    logic          r_addrOk;
    logic [1:0]    r_sel;
    logic [0:15]   r_rdataUp;
    logic [0:15]   r_rdataDown;
    logic [7:0]    r_injCount;

    logic          w_accept;
    logic          w_wrAccept;
    logic          w_rdAccept;
    logic          w_addrOk;
    logic          w_selUp;
    logic          w_selDown;
    logic          w_injHit;
    logic          w_rdSelUp;
    logic          w_rdSelDown;

    // sel: 00 = up only, 01 = down only, 1x = both banks.
    assign w_selUp     = bus.sel[1] | ~bus.sel[0];
    assign w_selDown   = bus.sel[1] |  bus.sel[0];
    assign w_rdSelUp   = r_sel[1]   | ~r_sel[0];
    assign w_rdSelDown = r_sel[1]   |  r_sel[0];

    // Only reachable addresses are valid; always true for power-of-2 DEPTH.
    assign w_addrOk   = {1'b0, bus.req_addr} < DEPTH_W;

    assign w_accept   = (r_state == IDLE) && bus.req_valid;
    assign w_wrAccept = w_accept &&  bus.req_we;
    assign w_rdAccept = w_accept && !bus.req_we;

    // An injection counts only if a selected bank actually gets a flipped bit,
    // regardless of whether the address is in range.
    assign w_injHit = w_wrAccept && bus.inj_en &&
                      ((w_selUp   && (bus.inj_mask_up   != '0)) ||
                       (w_selDown && (bus.inj_mask_down != '0)));

    // State register; reset discards any read in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and handshake outputs. Writes never leave IDLE, so they can
    // be accepted every cycle.
    always_comb begin
        w_stateNext = r_state;
        w_reqReady  = 1'b0;
        w_rspValid  = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_reqReady = 1'b1;
                if (bus.req_valid && !bus.req_we) begin
                    w_stateNext = READ;
                end
            end
            READ: begin
                w_stateNext = RESP;
            end
            RESP: begin
                w_rspValid = 1'b1;
                if (bus.rsp_ready) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Bank storage: writes land in the accept cycle, with the injection mask
    // folded in, so later reads need no forwarding.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_memUp[i]   <= '0;
                r_memDown[i] <= '0;
            end
        end else if (w_wrAccept && w_addrOk) begin
            if (w_selUp) begin
                r_memUp[bus.req_addr]   <= bus.wdata_up ^
                                           (bus.inj_en ? bus.inj_mask_up : 16'h0000);
            end
            if (w_selDown) begin
                r_memDown[bus.req_addr] <= bus.wdata_down ^
                                           (bus.inj_en ? bus.inj_mask_down : 16'h0000);
            end
        end
    end

    // Read request capture: address and bank select are frozen at acceptance
    // so requester inputs are free to change while the read is in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr   <= '0;
            r_addrOk <= 1'b0;
            r_sel    <= 2'b00;
        end else if (w_rdAccept) begin
            r_addr   <= bus.req_addr;
            r_addrOk <= w_addrOk;
            r_sel    <= bus.sel;
        end
    end

    // Read data register: loaded only in READ, so it holds steady through a
    // stalled RESP. Unselected banks and out-of-range addresses read as zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdataUp   <= '0;
            r_rdataDown <= '0;
        end else if (r_state == READ) begin
            r_rdataUp   <= (w_rdSelUp   && r_addrOk) ? r_memUp[r_addr]   : 16'h0000;
            r_rdataDown <= (w_rdSelDown && r_addrOk) ? r_memDown[r_addr] : 16'h0000;
        end
    end

    // Saturating count of writes that injected at least one fault bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_injCount <= '0;
        end else if (w_injHit && (r_injCount != 8'hFF)) begin
            r_injCount <= r_injCount + 8'd1;
        end
    end

    assign bus.req_ready  = w_reqReady;
    assign bus.rsp_valid  = w_rspValid;
    assign bus.rdata_up   = r_rdataUp;
    assign bus.rdata_down = r_rdataDown;
    assign bus.inj_count  = r_injCount;
endmodule
